// File: rtl/bch_pkg.sv
// rtl/bch_pkg.sv - shared (21,16) BCH/Hamming constants, result type and codeword helpers
package bch_pkg;

    localparam int CODE_W = 21;
    localparam int DATA_W = 16;
    localparam int SYN_W  = 5;

    // Highest syndrome that still names a bit inside the codeword
    localparam logic [SYN_W-1:0] SYN_MAX_CORR = 5'd21;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              corrected;
        logic              uncorrectable;
        logic [SYN_W-1:0]  syndrome;
    } bch_result_t;

    // Data bits sit at the non-power-of-two Hamming positions
    function automatic logic [DATA_W-1:0] bch_extract(input logic [CODE_W-1:0] code);
        return {code[20:16], code[14:8], code[6:4], code[2]};
    endfunction

    function automatic logic [SYN_W-1:0] bch_syndrome_of(input logic [CODE_W-1:0] code);
        logic [SYN_W-1:0] syn;
        syn = '0;
        for (int i = 0; i < CODE_W; i++) begin
            if (code[i]) begin
                syn = syn ^ SYN_W'(i + 1);
            end
        end
        return syn;
    endfunction

endpackage

// File: rtl/bch_syndrome.sv
// rtl/bch_syndrome.sv - combinational codeword to 5-bit syndrome
module bch_syndrome
    import bch_pkg::*;
(
    input  logic [20:0] code_i,
    output logic [4:0]  syndrome_o
);

    always_comb begin
        syndrome_o = bch_syndrome_of(code_i);
    end

endmodule

// File: rtl/bch_decoder.sv
// rtl/bch_decoder.sv - two-stage elastic (21,16) single-error-correcting decoder with statistics
module bch_decoder
    import bch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [20:0]      code_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      data_out,
    output logic             err_corrected,
    output logic             err_uncorrectable,
    output logic [4:0]       syndrome_out,
    input  logic             stat_clear,
    output logic [CNT_W-1:0] cnt_words,
    output logic [CNT_W-1:0] cnt_corrected,
    output logic [CNT_W-1:0] cnt_uncorrectable
);

    logic              s1_valid_q, s1_valid_d;
    logic [CODE_W-1:0] s1_code_q, s1_code_d;
    logic [SYN_W-1:0]  s1_syn_q, s1_syn_d;
    logic [SYN_W-1:0]  syn_w;

    logic              s2_valid_q, s2_valid_d;
    bch_result_t       s2_q, s2_d;
    bch_result_t       fix_w;
    logic [CODE_W-1:0] flip_mask;

    logic [CNT_W-1:0]  words_q, words_d;
    logic [CNT_W-1:0]  corr_q, corr_d;
    logic [CNT_W-1:0]  unc_q, unc_d;

    logic              in_fire;
    logic              s2_load;
    logic              out_fire;

    bch_syndrome u_syndrome (
        .code_i     (code_in),
        .syndrome_o (syn_w)
    );

    // S1 frees itself in the same cycle it hands off, so in_ready depends on out_ready
    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;

    // One-hot flip mask; syndromes above 21 match no position and leave the word untouched
    always_comb begin
        flip_mask = '0;
        for (int i = 0; i < CODE_W; i++) begin
            flip_mask[i] = (s1_syn_q == SYN_W'(i + 1));
        end
        fix_w.data          = bch_extract(s1_code_q ^ flip_mask);
        fix_w.corrected     = (s1_syn_q != '0) && (s1_syn_q <= SYN_MAX_CORR);
        fix_w.uncorrectable = (s1_syn_q > SYN_MAX_CORR);
        fix_w.syndrome      = s1_syn_q;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_syn_d   = s1_syn_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_code_d  = code_in;
            s1_syn_d   = syn_w;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_d       = fix_w;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_comb begin
        words_d = words_q;
        corr_d  = corr_q;
        unc_d   = unc_q;
        if (stat_clear) begin
            words_d = '0;
            corr_d  = '0;
            unc_d   = '0;
        end else if (out_fire) begin
            if (words_q != '1) begin
                words_d = words_q + 1'b1;
            end
            if (s2_q.corrected && (corr_q != '1)) begin
                corr_d = corr_q + 1'b1;
            end
            if (s2_q.uncorrectable && (unc_q != '1)) begin
                unc_d = unc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_syn_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
            words_q    <= '0;
            corr_q     <= '0;
            unc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_code_q  <= s1_code_d;
            s1_syn_q   <= s1_syn_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
            words_q    <= words_d;
            corr_q     <= corr_d;
            unc_q      <= unc_d;
        end
    end

    assign out_valid         = s2_valid_q;
    assign data_out          = s2_q.data;
    assign err_corrected     = s2_q.corrected;
    assign err_uncorrectable = s2_q.uncorrectable;
    assign syndrome_out      = s2_q.syndrome;
    assign cnt_words         = words_q;
    assign cnt_corrected     = corr_q;
    assign cnt_uncorrectable = unc_q;

endmodule

// File: tb/tb_bch_decoder.sv
// tb/tb_bch_decoder.sv - scoreboard bench for bch_decoder
module tb_bch_decoder;

    typedef struct packed {
        logic [15:0] data;
        logic        corr;
        logic        unc;
        logic [4:0]  syn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] code_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_out;
    logic        err_corrected;
    logic        err_uncorrectable;
    logic [4:0]  syndrome_out;
    logic        stat_clear;
    logic [15:0] cnt_words;
    logic [15:0] cnt_corrected;
    logic [15:0] cnt_uncorrectable;

    logic        in2_valid;
    logic        in2_ready;
    logic        out2_valid;
    logic        out2_ready;
    logic [15:0] data2_out;
    logic        corr2;
    logic        unc2;
    logic [4:0]  syn2;
    logic        clear2;
    logic [1:0]  cnt2_words;
    logic [1:0]  cnt2_corrected;
    logic [1:0]  cnt2_uncorrectable;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    logic prev_stall = 1'b0;
    exp_t prev_out;

    always #5 clk = ~clk;

    bch_decoder #(.CNT_W(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .code_in           (code_in),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .data_out          (data_out),
        .err_corrected     (err_corrected),
        .err_uncorrectable (err_uncorrectable),
        .syndrome_out      (syndrome_out),
        .stat_clear        (stat_clear),
        .cnt_words         (cnt_words),
        .cnt_corrected     (cnt_corrected),
        .cnt_uncorrectable (cnt_uncorrectable)
    );

    bch_decoder #(.CNT_W(2)) dut2 (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in2_valid),
        .in_ready          (in2_ready),
        .code_in           (21'h1FFFFE),
        .out_valid         (out2_valid),
        .out_ready         (out2_ready),
        .data_out          (data2_out),
        .err_corrected     (corr2),
        .err_uncorrectable (unc2),
        .syndrome_out      (syn2),
        .stat_clear        (clear2),
        .cnt_words         (cnt2_words),
        .cnt_corrected     (cnt2_corrected),
        .cnt_uncorrectable (cnt2_uncorrectable)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Builds a clean codeword from data by placing parity bits at positions 1,2,4,8,16
    function automatic logic [20:0] encode(input logic [15:0] d);
        logic [20:0] c;
        logic [4:0]  s;
        c = '0;
        c[2]     = d[0];
        c[6:4]   = d[3:1];
        c[14:8]  = d[10:4];
        c[20:16] = d[15:11];
        s = '0;
        for (int i = 0; i < 21; i++) begin
            if (c[i]) s = s ^ 5'(i + 1);
        end
        c[0]  = s[0];
        c[1]  = s[1];
        c[3]  = s[2];
        c[7]  = s[3];
        c[15] = s[4];
        return c;
    endfunction

    task automatic send(input logic [20:0] c, input exp_t e);
        int  n;
        bit  ok;
        n  = 0;
        ok = 0;
        in_valid = 1'b1;
        code_in  = c;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed %0b expected 1", in_ready);
        end else begin
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain_queue", q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t act;
        exp_t e;
        act = '{data: data_out, corr: err_corrected, unc: err_uncorrectable, syn: syndrome_out};
        if (rst_n) begin
            if (out_valid) begin
                checks++;
                if (err_corrected && err_uncorrectable) begin
                    failures++;
                    $display("FAIL both_flags: corr=1 unc=1 expected not both");
                end
            end
            if (prev_stall) begin
                checks++;
                if (!out_valid || act !== prev_out) begin
                    failures++;
                    $display("FAIL stall_hold: valid=%0b out=%h expected valid=1 out=%h", out_valid, act, prev_out);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: out=%h expected none", act);
                end else begin
                    e = q.pop_front();
                    if (act !== e) begin
                        failures++;
                        $display("FAIL word: data=%h corr=%0b unc=%0b syn=%0d expected data=%h corr=%0b unc=%0b syn=%0d",
                                 act.data, act.corr, act.unc, act.syn, e.data, e.corr, e.unc, e.syn);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = act;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        logic [15:0] d;
        int          b;
        int          n;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        code_in    = '0;
        out_ready  = 1'b1;
        stat_clear = 1'b0;
        in2_valid  = 1'b0;
        out2_ready = 1'b1;
        clear2     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_data", data_out, 0);
        check("rst_flags", {err_corrected, err_uncorrectable}, 0);
        check("rst_syn", syndrome_out, 0);
        check("rst_cnt_words", cnt_words, 0);
        check("rst_cnt_corr", cnt_corrected, 0);
        check("rst_cnt_unc", cnt_uncorrectable, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(21'h1FFFFE, '{data: 16'hFFFF, corr: 1'b0, unc: 1'b0, syn: 5'd0});
        check("latency_valid_early", out_valid, 0);
        @(posedge clk);
        #1;
        check("latency_valid", out_valid, 1);
        drain();
        check("cnt_words_1", cnt_words, 1);

        send(21'h000004, '{data: 16'h0000, corr: 1'b1, unc: 1'b0, syn: 5'd3});
        drain();
        check("cnt_corr_1", cnt_corrected, 1);

        send(21'h1FFFFF, '{data: 16'hFFFF, corr: 1'b1, unc: 1'b0, syn: 5'd1});
        drain();
        check("cnt_corr_2", cnt_corrected, 2);

        send(21'h008080, '{data: 16'h0000, corr: 1'b0, unc: 1'b1, syn: 5'd24});
        drain();
        check("cnt_unc_1", cnt_uncorrectable, 1);
        check("cnt_words_4", cnt_words, 4);

        send(21'h1FFFFF, '{data: 16'hFFFF, corr: 1'b1, unc: 1'b0, syn: 5'd1});
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        check("clear_wait_valid", out_valid, 1);
        stat_clear = 1'b1;
        @(posedge clk);
        #1;
        stat_clear = 1'b0;
        check("clear_words", cnt_words, 0);
        check("clear_corr", cnt_corrected, 0);
        check("clear_unc", cnt_uncorrectable, 0);
        drain();

        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    d = 16'($urandom);
                    if (k % 2 == 0) begin
                        b = $urandom_range(0, 20);
                        send(encode(d) ^ (21'h1 << b), '{data: d, corr: 1'b1, unc: 1'b0, syn: 5'(b + 1)});
                    end else begin
                        send(encode(d), '{data: d, corr: 1'b0, unc: 1'b0, syn: 5'd0});
                    end
                end
            end
            begin
                repeat (80) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_cnt_words", cnt_words, 8);

        out_ready = 1'b0;
        send(encode(16'h1234), '{data: 16'h1234, corr: 1'b0, unc: 1'b0, syn: 5'd0});
        send(encode(16'hABCD), '{data: 16'hABCD, corr: 1'b0, unc: 1'b0, syn: 5'd0});
        in_valid = 1'b1;
        code_in  = encode(16'h5555);
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        check("full_cnt_words", cnt_words, 10);

        out_ready = 1'b0;
        send(encode(16'h0F0F), '{data: 16'h0F0F, corr: 1'b0, unc: 1'b0, syn: 5'd0});
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_cnt_words", cnt_words, 0);
        q.delete();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_word", out_valid, 0);

        in2_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        in2_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("sat_cnt_words", cnt2_words, 3);
        check("sat_cnt_corr", cnt2_corrected, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
